// File: rtl/muldiv_unit_pkg.sv
// muldiv_codes: shared encodings and helpers for the RV32M multiply/divide unit.
//   MULDIV      - func7 value that marks an M-extension OP instruction
//   MUL..REMU   - func3 operation selects
//   muldiv_op_e - enumerated view of func3
//   rs1_signed / rs2_signed - operand signedness per op
//   neg_if      - two's-complement conditional negate (used for abs and sign fix-up)
package muldiv_codes;

    localparam logic [6:0] MULDIV = 7'b0000001;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM,    OP_REMU
    } muldiv_op_e;

    // Widest value the helpers handle (2*XLEN for XLEN up to 64).
    localparam int MDW = 128;

    function automatic logic rs1_signed(input logic [2:0] f);
        return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f);
        return (f == MULH) || (f == DIV) || (f == REM);
    endfunction

    // Callers zero-extend into MDW and truncate back; the low bits of the
    // negation are the correct narrow two's complement.
    function automatic logic [MDW-1:0] neg_if(input logic [MDW-1:0] x, input logic neg);
        return neg ? (~x + MDW'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, XLEN cycles of shift-add or
// restoring divide on operand magnitudes, with sign fix-up in FIN.
//   clk, rst          - clock, synchronous active-high reset
//   start, func3      - issue request and op select (sampled in IDLE only)
//   valA, valB        - rs1 / rs2 operands, sampled with start
//   flush             - abort an in-flight op (ITER/FIN), no done
//   stall, busy, done - pipeline hold, FSM active, one-cycle result strobe
//   result            - registered result, updated in FIN
module muldiv_unit
    import muldiv_codes::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] valA,
    input  logic [XLEN-1:0] valB,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIN, DONE} state_e;

    state_e            state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              dz_q, dz_d, ov_q, ov_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand capture
    logic a_neg, b_neg;
    assign a_neg = rs1_signed(func3) & valA[XLEN-1];
    assign b_neg = rs2_signed(func3) & valB[XLEN-1];

    // Restoring-divide step: hi half of acc is the partial remainder, low half
    // collects quotient bits, dividend bits stream out of opa MSB-first.
    // shifted <= 2*divisor-1, so bit XLEN of diff is a clean borrow flag.
    logic [XLEN:0] shifted, diff;
    logic          qbit;
    assign shifted = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
    assign diff    = shifted - {1'b0, opb_q};
    assign qbit    = ~diff[XLEN];

    // FIN fix-up
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    always_comb begin
        prod = (2*XLEN)'(neg_if(MDW'(acc_q), sa_q ^ sb_q));
        quo  = XLEN'(neg_if(MDW'(acc_q[XLEN-1:0]), sa_q ^ sb_q));
        rem  = XLEN'(neg_if(MDW'(acc_q[2*XLEN-1:XLEN]), sa_q));
        // The remainder for divide-by-zero already equals valA (|a| re-signed).
        if (dz_q) quo = '1;
        if (ov_q) begin
            quo = SMIN;
            rem = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        ov_d     = ov_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                op_d    = muldiv_op_e'(func3);
                opa_d   = XLEN'(neg_if(MDW'(valA), a_neg));
                opb_d   = XLEN'(neg_if(MDW'(valB), b_neg));
                sa_d    = a_neg;
                sb_d    = b_neg;
                dz_d    = func3[2] && (valB == '0);
                ov_d    = ((func3 == DIV) || (func3 == REM)) && (valA == SMIN) && (valB == '1);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                if (!op_q[2]) begin
                    // MSB-first shift-add: multiplier bits leave opb's top.
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0}
                          + (opb_q[XLEN-1] ? {{XLEN{1'b0}}, opa_q} : '0);
                    opb_d = opb_q << 1;
                end else begin
                    acc_d = {(qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0]),
                             acc_q[XLEN-2:0], qbit};
                    opa_d = opa_q << 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) state_d = FIN;
            end
            FIN: begin
                case (op_q)
                    OP_MUL:                        result_d = prod[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:               result_d = quo;
                    default:                       result_d = rem;
                endcase
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && (state_q == ITER || state_q == FIN)) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
            result_q <= result_d;
        end
    end

    assign stall  = ((state_q == IDLE) && start) || (state_q == ITER) || (state_q == FIN);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results,
// latency/stall timing, flush, mid-op reset and start-while-busy cases.
module tb_muldiv_unit;
    import muldiv_codes::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  func3;
    logic [31:0] valA, valB;
    logic        stall, busy, done;
    logic [31:0] result;

    int ncmp  = 0;
    int nfail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .func3(func3), .valA(valA), .valB(valB),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue at a negedge (cycle 0); sample each later negedge until done.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat, nstall;
        @(negedge clk);
        start = 1'b1; func3 = f; valA = a; valB = b;
        #1;
        lat = -1; nstall = 0;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                lat = k;
                chk({tag, "_stall_at_done"}, 32'(stall), 32'd0);
            end else if (stall) nstall++;
            if (k == 0) begin
                @(posedge clk); #1 start = 1'b0;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd34);
        chk({tag, "_stall_cycles"}, 32'(nstall), 32'd34);
        chk({tag, "_result"}, result, exp);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; func3 = f; valA = a; valB = b;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int nd, lat;
        rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'b0; valA = '0; valB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_busy",   32'(busy),  32'd0);
        chk("rst_done",   32'(done),  32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        rst = 1'b0;

        run_op("mul_7xm3",    MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mul_plain",   MUL,    32'h12345678, 32'h10,       32'h23456780);
        run_op("mulh_min",    MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhu_ones",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulhsu_ones", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div_m7_2",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_op("rem_m7_2",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_op("divu_100_7",  DIVU,   32'd100,      32'd7,        32'd14);
        run_op("remu_100_7",  REMU,   32'd100,      32'd7,        32'd2);
        run_op("divu_by0",    DIVU,   32'd7,        32'd0,        32'hFFFFFFFF);
        run_op("remu_by0",    REMU,   32'd7,        32'd0,        32'd7);
        run_op("div_m7_by0",  DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
        run_op("rem_m7_by0",  REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
        run_op("div_ovf",     DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf",     REM,    32'h80000000, 32'hFFFFFFFF, 32'h0);

        // flush at cycle 10: idle at 11, no done, result keeps the last value (0)
        issue(DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        count_done(40, nd);
        chk("flush_no_done", 32'(nd), 32'd0);
        chk("flush_result", result, 32'h0);

        // start while busy is ignored: first op completes alone at cycle 34
        issue(MUL, 32'd2, 32'd3);
        lat = -1;
        for (int k = 1; k < 60 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; func3 = MUL; valA = 32'd100; valB = 32'd100;
                @(posedge clk); #1 start = 1'b0;
            end else if (done) lat = k;
        end
        chk("busy_start_latency", 32'(lat), 32'd34);
        chk("busy_start_result", result, 32'd6);
        @(negedge clk);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // reset at cycle 20: result 0 and idle next cycle, no done
        issue(MUL, 32'd5, 32'd5);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_result", result, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        count_done(40, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
